// File: rtl/piso_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : piso_arb_ctrl
//  Purpose  : Two-requester serializer controller. Round-robin arbitration
//             between two parallel-word sources. The granted word is loaded
//             into a WIDTH-bit shift register and shifted out MSB-first, one
//             bit every DIV clock cycles. Each frame is marked with sof/eof,
//             and a one-cycle done pulse follows it.
//  Ports    : clk        - system clock, all state on posedge
//             rst        - synchronous active-high reset
//             req0/req1  - level requests, held until the matching grant
//             data0/data1- request words, sampled on the grant edge
//             gnt0/gnt1  - one-cycle pulse: word captured
//             sout       - serial data, MSB first
//             sout_valid - a frame bit is on sout
//             sof / eof  - first / last bit period of a frame
//             busy       - frame in progress (SHIFT state)
//             done       - one-cycle pulse in the idle cycle after a frame
//  Revision : 1.0 - initial release
// ============================================================================
module piso_arb_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic             done
);

    localparam int c_BIT_W = $clog2(WIDTH);
    localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_sr;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_last_gnt;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_done;

    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_sr_nxt;
    logic [c_BIT_W-1:0] w_bit_cnt_nxt;
    logic [c_DIV_W-1:0] w_div_cnt_nxt;
    logic               w_last_gnt_nxt;
    logic               w_gnt0_nxt;
    logic               w_gnt1_nxt;
    logic               w_done_nxt;
    logic               w_pick1;
    logic               w_shift;

    // Requester 1 wins when it is alone, or on a tie when requester 0
    // was the previous winner.
    assign w_pick1 = req1 & (~req0 | ~r_last_gnt);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_last_gnt <= 1'b1;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_gnt0     <= w_gnt0_nxt;
            r_gnt1     <= w_gnt1_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_sr_nxt       = r_sr;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_div_cnt_nxt  = r_div_cnt;
        w_last_gnt_nxt = r_last_gnt;
        w_gnt0_nxt     = 1'b0;
        w_gnt1_nxt     = 1'b0;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req0 | req1) begin
                    if (w_pick1) begin
                        w_sr_nxt       = data1;
                        w_gnt1_nxt     = 1'b1;
                        w_last_gnt_nxt = 1'b1;
                    end else begin
                        w_sr_nxt       = data0;
                        w_gnt0_nxt     = 1'b1;
                        w_last_gnt_nxt = 1'b0;
                    end
                    w_bit_cnt_nxt = '0;
                    w_div_cnt_nxt = '0;
                    w_state_nxt   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_div_cnt_nxt = '0;
                    w_sr_nxt      = {r_sr[WIDTH-2:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + c_BIT_W'(1);
                    if (r_bit_cnt == c_BIT_LAST) begin
                        // Clearing sr keeps sout low in IDLE by construction.
                        w_state_nxt   = S_IDLE;
                        w_done_nxt    = 1'b1;
                        w_sr_nxt      = '0;
                        w_bit_cnt_nxt = '0;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + c_DIV_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only
    // ------------------------------------------------------------------
    assign w_shift    = (r_state == S_SHIFT);
    assign busy       = w_shift;
    assign sout_valid = w_shift;
    assign sout       = w_shift & r_sr[WIDTH-1];
    assign sof        = w_shift & (r_bit_cnt == '0);
    assign eof        = w_shift & (r_bit_cnt == c_BIT_LAST);
    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_arb_ctrl
//  Purpose  : Self-checking bench for piso_arb_ctrl. Two instances share one
//             stimulus stream: WIDTH=4/DIV=1 and WIDTH=4/DIV=3. Each is
//             compared every cycle against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_arb_ctrl;

    localparam int c_W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0;
    logic           req1;
    logic [c_W-1:0] data0;
    logic [c_W-1:0] data1;

    logic [7:0] w_obs [2];

    logic a_gnt0, a_gnt1, a_sout, a_sval, a_sof, a_eof, a_busy, a_done;
    logic b_gnt0, b_gnt1, b_sout, b_sval, b_sof, b_eof, b_busy, b_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_arb_ctrl #(.WIDTH(c_W), .DIV(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .sout(a_sout), .sout_valid(a_sval),
        .sof(a_sof), .eof(a_eof), .busy(a_busy), .done(a_done)
    );

    piso_arb_ctrl #(.WIDTH(c_W), .DIV(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .sout(b_sout), .sout_valid(b_sval),
        .sof(b_sof), .eof(b_eof), .busy(b_busy), .done(b_done)
    );

    assign w_obs[0] = {a_gnt0, a_gnt1, a_sout, a_sval, a_sof, a_eof, a_busy, a_done};
    assign w_obs[1] = {b_gnt0, b_gnt1, b_sout, b_sval, b_sof, b_eof, b_busy, b_done};

    // ------------------------------------------------------------------
    // Reference model: a frame is a word plus a cycle index k counting
    // the WIDTH*DIV cycles of the frame; bit shown = word bit (W-1-k/DIV).
    // ------------------------------------------------------------------
    bit             m_busy [2];
    int             m_k    [2];
    bit             m_last [2];
    bit             m_gnt0 [2];
    bit             m_gnt1 [2];
    bit             m_done [2];
    logic [c_W-1:0] m_word [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_step(input int i);
        bit pick1;
        m_gnt0[i] = 1'b0;
        m_gnt1[i] = 1'b0;
        m_done[i] = 1'b0;
        if (rst) begin
            m_busy[i] = 1'b0;
            m_k[i]    = 0;
            m_last[i] = 1'b1;
            m_word[i] = '0;
        end else if (!m_busy[i]) begin
            if (req0 || req1) begin
                pick1     = req1 && (!req0 || (m_last[i] == 1'b0));
                m_word[i] = pick1 ? data1 : data0;
                m_gnt1[i] = pick1;
                m_gnt0[i] = !pick1;
                m_last[i] = pick1;
                m_busy[i] = 1'b1;
                m_k[i]    = 0;
            end
        end else if (m_k[i] == c_W * div_of(i) - 1) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
        end else begin
            m_k[i] = m_k[i] + 1;
        end
    endtask

    function automatic logic [7:0] model_exp(input int i);
        logic [c_W-1:0] w;
        int             bitpos;
        logic           s, sf, ef;
        w  = m_word[i];
        s  = 1'b0;
        sf = 1'b0;
        ef = 1'b0;
        if (m_busy[i]) begin
            bitpos = c_W - 1 - m_k[i] / div_of(i);
            s      = w[bitpos];
            sf     = (m_k[i] < div_of(i));
            ef     = (m_k[i] >= (c_W - 1) * div_of(i));
        end
        return {m_gnt0[i], m_gnt1[i], s, m_busy[i], sf, ef, m_busy[i], m_done[i]};
    endfunction

    task automatic check(input string tag, input int i);
        logic [7:0] exp_v;
        exp_v = model_exp(i);
        n_checks++;
        assert (w_obs[i] === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s div%0d gnt0,gnt1,sout,valid,sof,eof,busy,done got %b want %b",
                   tag, div_of(i), w_obs[i], exp_v);
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, then check.
    task automatic cyc(input string tag, input logic r, input logic q0, input logic q1,
                       input logic [c_W-1:0] d0, input logic [c_W-1:0] d1);
        rst   = r;
        req0  = q0;
        req1  = q1;
        data0 = d0;
        data1 = d1;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check(tag, 0);
        check(tag, 1);
    endtask

    task automatic idle(input string tag, input int n);
        for (int j = 0; j < n; j++) cyc(tag, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_k[i] = 0; m_last[i] = 1'b1;
            m_gnt0[i] = 1'b0; m_gnt1[i] = 1'b0; m_done[i] = 1'b0;
            m_word[i] = '0;
        end
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;

        // Reset held two cycles with req0 high: no grant, outputs low.
        cyc("reset", 1'b1, 1'b1, 1'b0, 4'b1011, 4'h0);
        cyc("reset", 1'b1, 1'b1, 1'b0, 4'b1011, 4'h0);

        // First grant at the first edge after reset releases; frame 1011.
        cyc("single_gnt", 1'b0, 1'b1, 1'b0, 4'b1011, 4'h0);
        for (int j = 0; j < 5; j++) cyc("single_frame", 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
        idle("settle", 12);

        // Both requesters held: alternating frames 1010 / 0101.
        for (int j = 0; j < 20; j++) cyc("tie_alt", 1'b0, 1'b1, 1'b1, 4'hA, 4'h5);
        idle("settle", 14);

        // Lone req1 held: back-to-back gnt1 frames with one idle gap.
        for (int j = 0; j < 16; j++) cyc("lone_req1", 1'b0, 1'b0, 1'b1, 4'h0, 4'h6);
        idle("settle", 14);

        // Bit period frame 1001 (DIV=3 instance holds each bit 3 cycles).
        cyc("bitper_gnt", 1'b0, 1'b1, 1'b0, 4'b1001, 4'h0);
        idle("bitper", 14);

        // Reset during the second bit, then tie goes to req0.
        cyc("midrst_gnt", 1'b0, 1'b1, 1'b0, 4'b1101, 4'h0);
        cyc("midrst_bit", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        cyc("midrst_rst", 1'b1, 1'b1, 1'b1, 4'hC, 4'h3);
        cyc("midrst_tie", 1'b0, 1'b1, 1'b1, 4'hC, 4'h3);
        cyc("midrst_run", 1'b0, 1'b0, 1'b1, 4'h0, 4'h3);
        idle("settle", 14);

        // Randomized traffic with occasional resets.
        for (int j = 0; j < 3000; j++) begin
            cyc("random", ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                c_W'($urandom), c_W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
